// File: rtl/bsg_wormhole_test_pkg.sv
// Shared header field layout and error codes for the wormhole test
// traffic generator and checker.
package bsg_wormhole_test_pkg;

  typedef enum logic [2:0] {
    err_none_e    = 3'd0,
    err_dest_e    = 3'd1,
    err_len_e     = 3'd2,
    err_seq_e     = 3'd3,
    err_payload_e = 3'd4
  } err_code_e;

  // Header is packed LSB first: x, y, len, reserved, seq.
  function automatic int x_lsb();
    return 0;
  endfunction

  function automatic int y_lsb(input int x_w);
    return x_w;
  endfunction

  function automatic int len_lsb(input int x_w, input int y_w);
    return x_w + y_w;
  endfunction

  function automatic int seq_lsb(input int x_w, input int y_w,
                                 input int len_w, input int res_w);
    return x_w + y_w + len_w + res_w;
  endfunction

  function automatic int seq_w(input int width, input int x_w, input int y_w,
                               input int len_w, input int res_w);
    return width - seq_lsb(x_w, y_w, len_w, res_w);
  endfunction

endpackage

// File: rtl/bsg_wormhole_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module bsg_wormhole_sat_counter #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               incr_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      count_r <= '0;
    else if (incr_i && (count_r != '1))
      count_r <= count_r + width_p'(1);
  end

  assign count_o = count_r;

endmodule

// File: rtl/bsg_wormhole_test_node_checker.sv
// Receive-side checker for wormhole test traffic: frames packets by header
// length and checks destination, length, sequence and body payload.
module bsg_wormhole_test_node_checker
  import bsg_wormhole_test_pkg::*;
#(
  parameter int width_p          = 32,
  parameter int x_cord_width_p   = 4,
  parameter int y_cord_width_p   = 4,
  parameter int len_width_p      = 4,
  parameter int reserved_width_p = 4,
  parameter int length_p         = 3,
  parameter int count_width_p    = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      enable_i,
  input  logic                      valid_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  output logic [count_width_p-1:0]  pkt_count_o,
  output logic [count_width_p-1:0]  err_count_o,
  output logic                      error_o,
  output logic [2:0]                err_code_o
);

  localparam int x_lsb_lp   = x_lsb();
  localparam int y_lsb_lp   = y_lsb(x_cord_width_p);
  localparam int len_lsb_lp = len_lsb(x_cord_width_p, y_cord_width_p);
  localparam int seq_lsb_lp = seq_lsb(x_cord_width_p, y_cord_width_p,
                                      len_width_p, reserved_width_p);
  localparam int seq_w_lp   = seq_w(width_p, x_cord_width_p, y_cord_width_p,
                                    len_width_p, reserved_width_p);

  typedef enum logic {head_s, body_s} state_e;

  state_e                   state_r, state_n;
  logic [len_width_p-1:0]   rem_r, rem_n, idx_r, idx_n;
  logic [seq_w_lp-1:0]      seq_r, seq_n, exp_seq_r, exp_seq_n;
  logic                     lock_r, lock_n, ready_r, error_r;
  err_code_e                err_code_r, err_sel;
  logic                     accept, pkt_inc, err_inc;

  logic [x_cord_width_p-1:0] hdr_x;
  logic [y_cord_width_p-1:0] hdr_y;
  logic [len_width_p-1:0]    hdr_len;
  logic [seq_w_lp-1:0]       hdr_seq;
  logic [width_p-1:0]        exp_body;

  assign hdr_x    = data_i[x_lsb_lp   +: x_cord_width_p];
  assign hdr_y    = data_i[y_lsb_lp   +: y_cord_width_p];
  assign hdr_len  = data_i[len_lsb_lp +: len_width_p];
  assign hdr_seq  = data_i[seq_lsb_lp +: seq_w_lp];
  assign exp_body = width_p'(seq_r) + width_p'(idx_r);
  assign accept   = valid_i & ready_r;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state_r;
    rem_n     = rem_r;
    idx_n     = idx_r;
    seq_n     = seq_r;
    exp_seq_n = exp_seq_r;
    lock_n    = lock_r;
    pkt_inc   = 1'b0;
    err_sel   = err_none_e;

    if (accept) begin
      if (state_r == head_s) begin
        // Framing follows the received len so a len error does not desync.
        rem_n     = hdr_len;
        idx_n     = len_width_p'(1);
        seq_n     = hdr_seq;
        exp_seq_n = hdr_seq + seq_w_lp'(1);
        lock_n    = 1'b1;
        if (hdr_len != '0) state_n = body_s;
        else               pkt_inc = 1'b1;

        if ((hdr_x != my_x_i) || (hdr_y != my_y_i))
          err_sel = err_dest_e;
        else if (hdr_len != len_width_p'(length_p))
          err_sel = err_len_e;
        else if (lock_r && (hdr_seq != exp_seq_r))
          err_sel = err_seq_e;
      end else begin
        if (data_i != exp_body) err_sel = err_payload_e;
        rem_n = rem_r - len_width_p'(1);
        idx_n = idx_r + len_width_p'(1);
        if (rem_r == len_width_p'(1)) begin
          state_n = head_s;
          pkt_inc = 1'b1;
        end
      end
    end
  end

  assign err_inc = (err_sel != err_none_e);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= head_s;
      rem_r      <= '0;
      idx_r      <= '0;
      seq_r      <= '0;
      exp_seq_r  <= '0;
      lock_r     <= 1'b0;
      ready_r    <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= err_none_e;
    end else begin
      state_r   <= state_n;
      rem_r     <= rem_n;
      idx_r     <= idx_n;
      seq_r     <= seq_n;
      exp_seq_r <= exp_seq_n;
      lock_r    <= lock_n;
      ready_r   <= enable_i;
      if (err_inc) begin
        error_r    <= 1'b1;
        err_code_r <= err_sel;
      end
    end
  end

  bsg_wormhole_sat_counter #(.width_p(count_width_p)) pkt_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (pkt_inc),
    .count_o   (pkt_count_o)
  );

  bsg_wormhole_sat_counter #(.width_p(count_width_p)) err_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (err_inc),
    .count_o   (err_count_o)
  );

  assign ready_o    = ready_r;
  assign error_o    = error_r;
  assign err_code_o = err_code_r;

endmodule

// File: doc/bsg_wormhole_test_node_checker.md
# bsg_wormhole_test_node_checker

Receive-side counterpart of the wormhole test traffic generator. It sinks the demultiplexed flit stream leaving a channel tunnel output port, in place of the tied-high ready. It reassembles packets from header length fields and checks destination, length, sequence number and body payload. It exposes saturating packet and error counters plus a sticky error flag for LEDs or chipscope.

## Interface
- width_p, 32, flit width
- x_cord_width_p, 4, header x field width
- y_cord_width_p, 4, header y field width
- len_width_p, 4, header length field width (number of body flits)
- reserved_width_p, 4, reserved field width; content ignored
- length_p, 3, expected body flits per packet; legal range 1..2^len_width_p-1
- count_width_p, 16, width of pkt/err counters
- clk_i  in  1  single clock; all logic on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- my_x_i  in  x_cord_width_p  expected dest x; quasi-static
- my_y_i  in  y_cord_width_p  expected dest y; quasi-static
- enable_i  in  1  enables acceptance
- valid_i  in  1  flit valid
- data_i  in  width_p  flit data
- ready_o  out  1  flit accepted when valid_i & ready_o
- pkt_count_o  out  count_width_p  completed packets, saturating
- err_count_o  out  count_width_p  detected errors, saturating
- error_o  out  1  sticky: set on first error, cleared only by reset
- err_code_o  out  3  code of most recent error: 0 none, 1 dest, 2 len, 3 seq, 4 payload

## Operation
- Header layout, LSB first: x [x_cord_width_p], y, len, reserved, seq (upper seq_w = width_p-x-y-len-reserved bits; 16 at defaults).
- Generator contract: seq increments by 1 per packet mod 2^seq_w. Body flit i (1..len) equals zero-extended seq + i, mod 2^width_p.
- FSM states:
  - HEAD: next accepted flit is a header.
  - BODY: remaining count rem_r is nonzero.
- HEAD, flit accepted:
  - rem_r = received len field. Packet is framed by the received len, not length_p, so framing survives a len error.
  - Latch seq. Go to BODY if len is nonzero. Otherwise the packet completes immediately: stay in HEAD and increment pkt_count.
- Header checks, priority dest > len > seq. One error per header, highest-priority code only:
  - dest: x != my_x_i or y != my_y_i.
  - len: len != length_p.
  - seq: seq != exp_seq_r while locked.
- Sequence lock: the first header after reset is not seq-checked and sets lock. On every header, exp_seq_r = received seq + 1 (resync after error).
- BODY, flit accepted:
  - Compare against seq_r + idx, idx counting 1..len; mismatch → payload error.
  - Decrement rem_r. At 0 return to HEAD and increment pkt_count, even if errors occurred.
- Each error increments err_count, sets error_o and loads err_code_o.
- Counters saturate at all-ones; no wrap.
- Deasserting enable_i mid-packet only stalls acceptance; FSM state is preserved.

## Timing
- Reset values: ready_o 0, pkt_count_o 0, err_count_o 0, error_o 0, err_code_o 0, FSM HEAD, lock 0, rem_r 0.
- ready_o is a register: it equals enable_i delayed one cycle, and is 0 during reset. It is never combinationally dependent on valid_i.
- Throughput: one flit per cycle, no bubbles between packets.
- Latency: all outputs update on the clock edge that accepts the flit, visible the next cycle.
- No accept when valid_i=1 & ready_o=0; data_i is ignored.
- Header and body error on the same cycle cannot occur (one flit per cycle).
- Async reset mid-packet: immediate return to reset values. Partial packet is discarded and not counted.

## Structure
- Shared package bsg_wormhole_test_pkg:
  - Field offset/width localparam functions: x_lsb, y_lsb, len_lsb, seq_lsb, seq_w.
  - Error code enum (none/dest/len/seq/payload).
  - Usable by the generator too.
- Sub-module bsg_wormhole_sat_counter, count_width_p wide with increment input; instantiated twice, for pkt and err.
- Remaining logic (FSM, checks) is flat in the top module.

## Test plan
Defaults; my_x=3, my_y=5, enable=1.
- Good stream: headers 0x00000353 / 0x00010353 with bodies 1,2,3 / 2,3,4, back-to-back → pkt_count=2, err_count=0, error_o=0, ready_o held 1.
- Dest error: header 0x00000354 (x=4), body 1,2,3 → err_count=1, err_code=1, pkt_count=1; following 0x00010353 packet is clean.
- Len error and reframe: header 0x00000253 (len=2), bodies 1,2, then good 0x00010353 → err_code=2, err_count=1, pkt_count=2, no payload errors.
- Seq skip: seq 0 then seq 2 (0x00020353, bodies 3,4,5), then seq 3 → err_count=1, err_code=3, resynced with no further errors.
- Payload and stall: body flit 2 sent as 0x7; enable dropped 4 cycles mid-packet with valid high → err_code=4, no accept while ready_o=0, packet completes after re-enable.
- Reset and saturation: async reset asserted between body flits 1 and 2 → all outputs return to reset values. With count_width_p=2, five errors → err_count_o=3.
